// File: rtl/alu_muldiv.sv
// Iterative RV32M-style multiply/divide unit: shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply for MUL-class ops.
module alu_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_1,
  input  logic [XLEN-1:0] in_2,
  input  logic [2:0]      muldiv_control,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            zero_flag,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned W2 = 2 * XLEN;
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [1:0]      op, op_nx;
  logic            neg_hi, neg_hi_nx;
  logic            neg_lo, neg_lo_nx;
  logic [XLEN-1:0] mag, mag_nx;
  logic [W2-1:0]   acc, acc_nx;
  logic [XLEN-1:0] res, res_nx;

  // Operand signedness and magnitudes at acceptance
  logic            sign_1, sign_2;
  logic [XLEN-1:0] mag_1, mag_2;

  assign sign_1 = in_1[XLEN-1] & (muldiv_control[2] ? ~muldiv_control[0]
                                                    : (muldiv_control[1:0] != 2'b11));
  assign sign_2 = in_2[XLEN-1] & (muldiv_control[2] ? ~muldiv_control[0] : ~muldiv_control[1]);
  assign mag_1  = sign_1 ? -in_1 : in_1;
  assign mag_2  = sign_2 ? -in_2 : in_2;

  // acc holds {partial product high, multiplier} for MUL and {remainder, quotient} for DIV
  logic [W2-1:0] mul_raw, mul_fin;
  logic [XLEN-1:0] mul_res;

`ifdef MULDIV_FAST_MUL_EN
  assign mul_raw = W2'(mag) * W2'(acc[XLEN-1:0]);
`else
  logic [XLEN:0] mul_sum;
  assign mul_sum = {1'b0, acc[W2-1:XLEN]} + (acc[0] ? {1'b0, mag} : {(XLEN+1){1'b0}});
  assign mul_raw = {mul_sum, acc[XLEN-1:1]};
`endif

  assign mul_fin = neg_hi ? -mul_raw : mul_raw;
  assign mul_res = (op == 2'b00) ? mul_fin[XLEN-1:0] : mul_fin[W2-1:XLEN];

  logic [XLEN:0]   div_sh, div_diff;
  logic [W2-1:0]   div_step;
  logic [XLEN-1:0] quot, rem, div_res;

  assign div_sh   = acc[W2-1:XLEN-1];
  assign div_diff = div_sh - {1'b0, mag};
  assign div_step = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign quot     = neg_hi ? -div_step[XLEN-1:0] : div_step[XLEN-1:0];
  assign rem      = neg_lo ? -div_step[W2-1:XLEN] : div_step[W2-1:XLEN];
  assign div_res  = op[1] ? rem : quot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      mag    <= '0;
      acc    <= '0;
      res    <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      op     <= op_nx;
      neg_hi <= neg_hi_nx;
      neg_lo <= neg_lo_nx;
      mag    <= mag_nx;
      acc    <= acc_nx;
      res    <= res_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    op_nx     = op;
    neg_hi_nx = neg_hi;
    neg_lo_nx = neg_lo;
    mag_nx    = mag;
    acc_nx    = acc;
    res_nx    = res;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          op_nx     = muldiv_control[1:0];
          cnt_nx    = CNT_LAST;
          neg_hi_nx = sign_1 ^ sign_2;
          neg_lo_nx = sign_1;
          mag_nx    = muldiv_control[2] ? mag_2 : mag_1;
          acc_nx    = {{XLEN{1'b0}}, (muldiv_control[2] ? mag_1 : mag_2)};
          if (!muldiv_control[2]) begin
            state_nx = MUL;
          end else if (in_2 == '0) begin
            res_nx   = muldiv_control[1] ? in_1 : '1;
            state_nx = DONE;
          end else if (!muldiv_control[0] && in_1 == MIN_NEG && in_2 == '1) begin
            res_nx   = muldiv_control[1] ? '0 : in_1;
            state_nx = DONE;
          end else begin
            state_nx = DIV;
          end
        end
      end
      MUL: begin
        if (kill) begin
          state_nx = IDLE;
        end else begin
`ifdef MULDIV_FAST_MUL_EN
          res_nx   = mul_res;
          state_nx = DONE;
`else
          acc_nx = mul_raw;
          if (cnt == '0) begin
            res_nx   = mul_res;
            state_nx = DONE;
          end else begin
            cnt_nx = cnt - CW'(1);
          end
`endif
        end
      end
      DIV: begin
        if (kill) begin
          state_nx = IDLE;
        end else begin
          acc_nx = div_step;
          if (cnt == '0) begin
            res_nx   = div_res;
            state_nx = DONE;
          end else begin
            cnt_nx = cnt - CW'(1);
          end
        end
      end
      DONE: begin
        if (kill || out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out       = res;
  assign zero_flag = (state == DONE) && (res == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (XLEN=32), one task per scenario.
module tb_alu_muldiv;

  localparam int unsigned XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_1, in_2;
  logic [2:0]      muldiv_control;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out;
  logic            zero_flag;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  alu_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_1(in_1), .in_2(in_2), .muldiv_control(muldiv_control), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zero_flag(zero_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for out_valid; lat counts the acceptance edge as 1.
  task automatic issue_wait(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; muldiv_control = c; in_1 = a; in_2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out !== 32'h0 || zero_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b out=%h zf=%b, want 1 0 0 0 0",
               in_ready, out_valid, busy, out, zero_flag);
    end
  endtask

  task automatic test_mul;
    logic [2:0]  c [6] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b011, 3'b001};
    logic [31:0] a [6] = '{32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h7, 32'hFFFFFFFF, 32'h12345678};
    logic [31:0] b [6] = '{32'h80000000, 32'h1234, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h10};
    logic [31:0] e [6] = '{32'h40000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFFE, 32'h1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue_wait(c[i], a[i], b[i], lat);
      checks++;
      if (out !== e[i]) begin failures++; $display("FAIL mul_out[%0d]: got %h want %h", i, out, e[i]); end
      checks++;
      if (lat != MUL_LAT) begin failures++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, MUL_LAT); end
      checks++;
      if (zero_flag !== (e[i] == 32'h0)) begin
        failures++; $display("FAIL mul_zero_flag[%0d]: got %b want %b", i, zero_flag, e[i] == 32'h0);
      end
      consume();
    end
  endtask

  task automatic test_div;
    logic [2:0]  c [7] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101};
    logic [31:0] a [7] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd100, 32'd7, 32'd7, 32'h80000000};
    logic [31:0] b [7] = '{32'd2, 32'd2, 32'h10, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [31:0] e [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h0FFFFFFF, 32'd2, 32'hFFFFFFFD, 32'd1, 32'h0};
    int lat;
    for (int i = 0; i < 7; i++) begin
      issue_wait(c[i], a[i], b[i], lat);
      checks++;
      if (out !== e[i]) begin failures++; $display("FAIL div_out[%0d]: got %h want %h", i, out, e[i]); end
      checks++;
      if (lat != DIV_LAT) begin failures++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, DIV_LAT); end
      checks++;
      if (zero_flag !== (e[i] == 32'h0)) begin
        failures++; $display("FAIL div_zero_flag[%0d]: got %b want %b", i, zero_flag, e[i] == 32'h0);
      end
      consume();
    end
  endtask

  task automatic test_div_special;
    logic [2:0]  c [5] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b100};
    logic [31:0] a [5] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF6};
    logic [31:0] b [5] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    logic [31:0] e [5] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF};
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue_wait(c[i], a[i], b[i], lat);
      checks++;
      if (out !== e[i]) begin failures++; $display("FAIL special_out[%0d]: got %h want %h", i, out, e[i]); end
      checks++;
      if (lat != 1) begin failures++; $display("FAIL special_latency[%0d]: got %0d want 1", i, lat); end
      checks++;
      if (zero_flag !== (e[i] == 32'h0)) begin
        failures++; $display("FAIL special_zero_flag[%0d]: got %b want %b", i, zero_flag, e[i] == 32'h0);
      end
      consume();
    end
  endtask

  task automatic test_backpressure;
    int lat;
    issue_wait(3'b101, 32'd100, 32'd7, lat);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out !== 32'd14 || out_valid !== 1'b1 || in_ready !== 1'b0 || zero_flag !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable[%0d]: got out=%h vld=%b rdy=%b zf=%b, want 0000000e 1 0 0",
                 i, out, out_valid, in_ready, zero_flag);
      end
      @(posedge clk); #1;
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL release_idle: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    issue_wait(3'b000, 32'd6, 32'd7, lat);
    checks++;
    if (out !== 32'd42 || lat != MUL_LAT) begin
      failures++; $display("FAIL after_release: got out=%h lat=%0d want 0000002a %0d", out, lat, MUL_LAT);
    end
    consume();
  endtask

  task automatic test_back_to_back;
    int lat;
    issue_wait(3'b101, 32'd50, 32'd5, lat);
    // Present a new request during the consuming edge; it must not be taken there.
    out_ready = 1'b1; in_valid = 1'b1; muldiv_control = 3'b000; in_1 = 32'd3; in_2 = 32'd5;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL no_overlap: got busy=%b rdy=%b vld=%b want 0 1 0", busy, in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL accept_after_idle: got busy=%b want 1", busy); end
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    checks++;
    if (out !== 32'd15 || lat != MUL_LAT) begin
      failures++; $display("FAIL b2b_result: got out=%h lat=%0d want 0000000f %0d", out, lat, MUL_LAT);
    end
    consume();
  endtask

  task automatic test_kill;
    int lat;
    bit seen = 0;
    // kill in IDLE must not block acceptance
    kill = 1'b1; in_valid = 1'b1; muldiv_control = 3'b100; in_1 = 32'd1000; in_2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL kill_idle_noeffect: got busy=%b want 1", busy); end
    repeat (14) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL kill_div: got rdy=%b busy=%b vld=%b want 1 0 0", in_ready, busy, out_valid);
    end
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL kill_no_result: got out_valid seen=%b want 0", seen); end
    issue_wait(3'b000, 32'd2, 32'd2, lat);
    kill = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL kill_done: got vld=%b busy=%b want 0 0", out_valid, busy);
    end
    issue_wait(3'b100, 32'd1000, 32'd3, lat);
    checks++;
    if (out !== 32'd333 || lat != DIV_LAT) begin
      failures++; $display("FAIL after_kill: got out=%h lat=%0d want 0000014d %0d", out, lat, DIV_LAT);
    end
    consume();
  endtask

  task automatic test_reset_mid;
    int lat;
    in_valid = 1'b1; muldiv_control = 3'b001; in_1 = 32'h80000000; in_2 = 32'h80000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out !== 32'h0 || zero_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_op: got rdy=%b vld=%b busy=%b out=%h zf=%b, want 1 0 0 0 0",
               in_ready, out_valid, busy, out, zero_flag);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    issue_wait(3'b001, 32'h80000000, 32'h80000000, lat);
    checks++;
    if (out !== 32'h40000000 || lat != MUL_LAT) begin
      failures++; $display("FAIL after_reset: got out=%h lat=%0d want 40000000 %0d", out, lat, MUL_LAT);
    end
    consume();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_1 = '0; in_2 = '0; muldiv_control = '0;
    kill = 1'b0; out_ready = 1'b0;
    #12;
    test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    test_mul();
    test_div();
    test_div_special();
    test_backpressure();
    test_back_to_back();
    test_kill();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
